// File: rtl/sram_bus_responder.sv
// sram_bus_responder: SRAM-like wrap_* bus target backed by a 16-bit block RAM with programmable latency
module sram_bus_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_addr,
    input  logic        i_cs,
    input  logic        i_l,
    input  logic        i_u,
    input  logic        i_we,
    input  logic [15:0] i_wr,
    input  logic        i_big_r,
    output logic [15:0] o_rd,
    output logic [47:0] o_rd48,
    output logic        o_ready,
    output logic [31:0] o_wr_cnt,
    output logic [31:0] o_rd_cnt
);
    localparam int CW = $clog2(LATENCY + 4);
    typedef enum logic [1:0] {IDLE, BUSY, BURST, RELEASE} state_t;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] a, raddr;
    logic [15:0]       wr, mem_q;
    logic              we, l, u, big, exec, addr_unused;
    logic [CW-1:0]     cnt;
    logic [15:0]       mem [2**ADDR_W];
    assign addr_unused = ^i_addr[31:ADDR_W];
    assign exec = state == BUSY && cnt == '0;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = i_cs ? BUSY : IDLE;
            BUSY:    state_nx = !exec ? BUSY : (!we && big) ? BURST : RELEASE;
            BURST:   state_nx = cnt == CW'(3) ? RELEASE : BURST;
            RELEASE: state_nx = i_cs ? RELEASE : IDLE;
            default: state_nx = IDLE;
        endcase
        // read port runs one word ahead so the RAM output register is always primed
        raddr = state == IDLE ? i_addr[ADDR_W-1:0] :
                state == BURST ? a + ADDR_W'(cnt) + ADDR_W'(1) : a;
    end
    always_ff @(posedge i_clk) begin
        mem_q <= mem[raddr];
        if (exec && we && l) mem[a][7:0] <= wr[7:0];
        if (exec && we && u) mem[a][15:8] <= wr[15:8];
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            o_ready  <= 1'b1;
            o_rd     <= '0;
            o_rd48   <= '0;
            o_wr_cnt <= '0;
            o_rd_cnt <= '0;
            a        <= '0;
            wr       <= '0;
            we       <= 1'b0;
            l        <= 1'b0;
            u        <= 1'b0;
            big      <= 1'b0;
            cnt      <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (i_cs) begin
                    a       <= i_addr[ADDR_W-1:0];
                    wr      <= i_wr;
                    we      <= i_we;
                    l       <= i_l;
                    u       <= i_u;
                    big     <= i_big_r;
                    o_ready <= 1'b0;
                    cnt     <= CW'(LATENCY - 1);
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (exec) begin
                        if (we) o_wr_cnt <= o_wr_cnt + 32'd1;
                        else if (big) cnt <= '0;
                        else begin
                            o_rd     <= mem_q;
                            o_rd_cnt <= o_rd_cnt + 32'd1;
                        end
                    end
                end
                BURST: begin
                    cnt <= cnt + CW'(1);
                    case (cnt[1:0])
                        2'd0:    o_rd <= mem_q;
                        2'd1:    o_rd48[47:32] <= mem_q;
                        2'd2:    o_rd48[31:16] <= mem_q;
                        default: begin
                            o_rd48[15:0] <= mem_q;
                            o_rd_cnt     <= o_rd_cnt + 32'd1;
                        end
                    endcase
                end
                RELEASE: if (!i_cs) o_ready <= 1'b1;
                default: o_ready <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_bus_responder.sv
// tb_sram_bus_responder: directed vector table plus randomized traffic against an array model
module tb_sram_bus_responder;
    localparam int AW = 6, LAT = 4, DEPTH = 1 << AW;
    logic        clk = 0, rst_n = 0;
    logic [31:0] addr = 0;
    logic        cs = 0, l = 0, u = 0, we = 0, big = 0;
    logic [15:0] wr = 0;
    logic [15:0] rd;
    logic [47:0] rd48;
    logic        ready;
    logic [31:0] wcnt, rcnt;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    sram_bus_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_cs(cs), .i_l(l), .i_u(u),
        .i_we(we), .i_wr(wr), .i_big_r(big), .o_rd(rd), .o_rd48(rd48),
        .o_ready(ready), .o_wr_cnt(wcnt), .o_rd_cnt(rcnt)
    );

    typedef struct {
        bit          w, bl, bu, bb;
        logic [31:0] ad;
        logic [15:0] d;
        logic [15:0] erd;
        logic [47:0] erd48;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int exp_low(input bit w, input bit bb, input int hold);
        int base;
        base = (!w && bb) ? LAT + 5 : LAT + 1;
        return hold > base ? hold : base;
    endfunction

    // One bus transaction; request fields are scrambled while busy to prove they were latched.
    task automatic xact(input bit w, input bit bl, input bit bu, input bit bb, input logic [31:0] ad,
                        input logic [15:0] d, input int hold, output int low);
        @(negedge clk);
        addr = ad; we = w; l = bl; u = bu; big = bb; wr = d; cs = 1;
        low = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ready) break;
            low++;
            addr = $urandom; wr = 16'($urandom); we = 1'($urandom);
            l = 1'($urandom); u = 1'($urandom); big = 1'($urandom);
            if (low >= hold) cs = 0;
        end
        cs = 0;
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL timeout ready stuck low actual=0 required=1");
        end
    endtask

    vec_t        v[18];
    logic [15:0] m[DEPTH];
    logic [15:0] mrd;
    logic [47:0] mrd48;
    int          ew, er, low, hold, ai;
    bit          rw, rl, ru, rb;
    logic [31:0] ra;
    logic [15:0] rdat;

    initial begin
        v[0]  = '{1, 1, 1, 0, 32'd5,          16'h1234, 16'h0000, 48'h0};
        v[1]  = '{0, 1, 1, 0, 32'd5,          16'h0000, 16'h1234, 48'h0};
        v[2]  = '{1, 1, 1, 0, 32'd7,          16'hFFFF, 16'h1234, 48'h0};
        v[3]  = '{1, 1, 0, 0, 32'd7,          16'h00AA, 16'h1234, 48'h0};
        v[4]  = '{0, 1, 1, 0, 32'd7,          16'h0000, 16'hFFAA, 48'h0};
        v[5]  = '{1, 0, 1, 0, 32'd7,          16'h5500, 16'hFFAA, 48'h0};
        v[6]  = '{0, 1, 1, 0, 32'd7,          16'h0000, 16'h55AA, 48'h0};
        v[7]  = '{1, 1, 1, 0, 32'd62,         16'h00A0, 16'h55AA, 48'h0};
        v[8]  = '{1, 1, 1, 0, 32'd63,         16'h00A1, 16'h55AA, 48'h0};
        v[9]  = '{1, 1, 1, 0, 32'd0,          16'h00A2, 16'h55AA, 48'h0};
        v[10] = '{1, 1, 1, 0, 32'd1,          16'h00A3, 16'h55AA, 48'h0};
        v[11] = '{0, 1, 1, 1, 32'd62,         16'h0000, 16'h00A0, 48'h00A1_00A2_00A3};
        v[12] = '{1, 1, 1, 0, 32'd9,          16'h0F0F, 16'h00A0, 48'h00A1_00A2_00A3};
        v[13] = '{1, 0, 0, 0, 32'd9,          16'hBEEF, 16'h00A0, 48'h00A1_00A2_00A3};
        v[14] = '{0, 1, 1, 0, 32'd9,          16'h0000, 16'h0F0F, 48'h00A1_00A2_00A3};
        v[15] = '{1, 1, 1, 1, 32'd62,         16'hC0C0, 16'h0F0F, 48'h00A1_00A2_00A3};
        v[16] = '{0, 0, 0, 0, 32'd62,         16'h0000, 16'hC0C0, 48'h00A1_00A2_00A3};
        v[17] = '{0, 1, 1, 0, 32'hFFFF_FFC5, 16'h0000, 16'h1234, 48'h00A1_00A2_00A3};

        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(ready), 1);
        chk("reset_rd", 64'(rd), 0);
        chk("reset_rd48", 64'(rd48), 0);
        chk("reset_wcnt", 64'(wcnt), 0);
        chk("reset_rcnt", 64'(rcnt), 0);
        rst_n = 1;

        ew = 0; er = 0;
        foreach (v[i]) begin
            xact(v[i].w, v[i].bl, v[i].bu, v[i].bb, v[i].ad, v[i].d, 1, low);
            if (v[i].w) ew++; else er++;
            chk($sformatf("vec%0d_rd", i), 64'(rd), 64'(v[i].erd));
            chk($sformatf("vec%0d_rd48", i), 64'(rd48), 64'(v[i].erd48));
            chk($sformatf("vec%0d_low", i), 64'(low), 64'(exp_low(v[i].w, v[i].bb, 1)));
            chk($sformatf("vec%0d_wcnt", i), 64'(wcnt), 64'(ew));
            chk($sformatf("vec%0d_rcnt", i), 64'(rcnt), 64'(er));
        end

        xact(0, 1, 1, 0, 32'd5, 16'h0, 20, low);
        er++;
        chk("hold_low", 64'(low), 20);
        chk("hold_rd", 64'(rd), 16'h1234);
        repeat (6) @(negedge clk);
        chk("hold_idle_ready", 64'(ready), 1);
        chk("hold_rcnt", 64'(rcnt), 64'(er));
        chk("hold_wcnt", 64'(wcnt), 64'(ew));

        @(negedge clk);
        addr = 5; we = 1; l = 1; u = 1; big = 0; wr = 16'hDEAD; cs = 1;
        @(negedge clk);
        cs = 0;
        @(negedge clk);
        chk("abort_busy", 64'(ready), 0);
        rst_n = 0;
        #1;
        chk("abort_ready", 64'(ready), 1);
        chk("abort_rd", 64'(rd), 0);
        chk("abort_rd48", 64'(rd48), 0);
        chk("abort_wcnt", 64'(wcnt), 0);
        chk("abort_rcnt", 64'(rcnt), 0);
        @(negedge clk);
        rst_n = 1;
        xact(0, 1, 1, 0, 32'd5, 16'h0, 1, low);
        chk("abort_no_commit", 64'(rd), 16'h1234);
        chk("abort_rcnt_after", 64'(rcnt), 1);
        chk("abort_wcnt_after", 64'(wcnt), 0);

        ew = 0; er = 1; mrd = rd; mrd48 = rd48;
        for (int a = 0; a < DEPTH; a++) begin
            rdat = 16'($urandom);
            xact(1, 1, 1, 0, 32'(a), rdat, 1, low);
            m[a] = rdat;
            ew++;
        end
        chk("init_wcnt", 64'(wcnt), 64'(ew));
        for (int n = 0; n < 300; n++) begin
            rw = 1'($urandom); rl = 1'($urandom); ru = 1'($urandom);
            rb = $urandom_range(0, 2) == 0;
            ra = $urandom; rdat = 16'($urandom); hold = $urandom_range(1, 12);
            xact(rw, rl, ru, rb, ra, rdat, hold, low);
            ai = int'(ra % DEPTH);
            if (rw) begin
                if (rl) m[ai][7:0] = rdat[7:0];
                if (ru) m[ai][15:8] = rdat[15:8];
                ew++;
            end else begin
                mrd = m[ai];
                if (rb) mrd48 = {m[(ai + 1) % DEPTH], m[(ai + 2) % DEPTH], m[(ai + 3) % DEPTH]};
                er++;
            end
            chk("rand_rd", 64'(rd), 64'(mrd));
            chk("rand_rd48", 64'(rd48), 64'(mrd48));
            chk("rand_low", 64'(low), 64'(exp_low(rw, rb, hold)));
            chk("rand_wcnt", 64'(wcnt), 64'(ew));
            chk("rand_rcnt", 64'(rcnt), 64'(er));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
